// File: rtl/booth_mul_arbiter_if.sv
// booth_mul_arbiter_if: requester, response, core and status signals of the shared Booth multiplier arbiter
interface booth_mul_arbiter_if #(parameter int WIDTH = 16);
  logic                 req0_valid, req0_ready;
  logic [WIDTH-1:0]     req0_a, req0_b;
  logic                 rsp0_valid, rsp0_ready;
  logic [2*WIDTH-1:0]   rsp0_prod;
  logic                 req1_valid, req1_ready;
  logic [WIDTH-1:0]     req1_a, req1_b;
  logic                 rsp1_valid, rsp1_ready;
  logic [2*WIDTH-1:0]   rsp1_prod;
  logic                 core_start;
  logic [WIDTH:0]       core_a, core_b;
  logic                 core_done;
  logic [2*WIDTH+1:0]   core_prod;
  logic                 err_timeout;
  modport slave (
    input  req0_valid, req0_a, req0_b, rsp0_ready,
    input  req1_valid, req1_a, req1_b, rsp1_ready,
    input  core_done, core_prod,
    output req0_ready, rsp0_valid, rsp0_prod,
    output req1_ready, rsp1_valid, rsp1_prod,
    output core_start, core_a, core_b, err_timeout
  );
  modport master (
    output req0_valid, req0_a, req0_b, rsp0_ready,
    output req1_valid, req1_a, req1_b, rsp1_ready,
    output core_done, core_prod,
    input  req0_ready, rsp0_valid, rsp0_prod,
    input  req1_ready, rsp1_valid, rsp1_prod,
    input  core_start, core_a, core_b, err_timeout
  );
endinterface

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin sharing of one sequential Booth multiplier core between two requesters
module booth_mul_arbiter #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 40
) (
  input logic clk,
  input logic rst,
  booth_mul_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t             state_q, state_d;
  logic               prio_q, owner_q, err_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CW-1:0]      cnt_q;
  logic               gnt0, gnt1, timeout, rsp_hs;
  assign gnt0    = bus.req0_valid & (~bus.req1_valid | ~prio_q);
  assign gnt1    = bus.req1_valid & (~bus.req0_valid | prio_q);
  assign timeout = cnt_q == CW'(TIMEOUT - 1);
  assign rsp_hs  = (state_q == RESP) & (owner_q ? bus.rsp1_ready : bus.rsp0_ready);
  assign bus.core_a      = {1'b0, a_q};
  assign bus.core_b      = {1'b0, b_q};
  assign bus.err_timeout = err_q;
  // next state and handshake outputs; operands stay zero-extended so signed Booth gives the unsigned product
  always_comb begin
    state_d        = state_q;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.core_start = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    bus.rsp0_prod  = '0;
    bus.rsp1_prod  = '0;
    unique case (state_q)
      IDLE: begin
        bus.req0_ready = gnt0;
        bus.req1_ready = gnt1;
        state_d        = (gnt0 | gnt1) ? ISSUE : IDLE;
      end
      ISSUE: begin
        bus.core_start = 1'b1;
        state_d        = WAIT;
      end
      WAIT: state_d = (bus.core_done | timeout) ? RESP : WAIT;
      RESP: begin
        bus.rsp0_valid = ~owner_q;
        bus.rsp1_valid = owner_q;
        bus.rsp0_prod  = owner_q ? '0 : prod_q;
        bus.rsp1_prod  = owner_q ? prod_q : '0;
        state_d        = rsp_hs ? IDLE : RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  // state register, operand/owner capture, watchdog counter and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      err_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: if (gnt0 | gnt1) begin
          owner_q <= gnt1;
          a_q     <= gnt1 ? bus.req1_a : bus.req0_a;
          b_q     <= gnt1 ? bus.req1_b : bus.req0_b;
        end
        ISSUE: cnt_q <= '0;
        WAIT: begin
          if (bus.core_done) prod_q <= bus.core_prod[2*WIDTH-1:0];
          else if (timeout) begin
            err_q  <= 1'b1;
            prod_q <= '0;
          end else cnt_q <= cnt_q + 1'b1;
        end
        RESP: if (rsp_hs) prio_q <= ~owner_q;
        default: ;
      endcase
    end
  end
endmodule
